// File: rtl/query_frame_loader.sv
// ============================================================================
// Module   : query_frame_loader
// Brief    : Finds a sync word in the toggle-strobed host word stream, collects
//            DIM query elements plus k, and presents them with valid/ready.
//            Optional build macro QUERY_CHECKSUM_EN adds a trailing checksum word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module query_frame_loader #(
    parameter int          DIM            = 8,
    parameter int          K_W            = 16,
    parameter logic [31:0] SYNC_WORD      = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           word_in,
    input  logic                  strobe_in,
    input  logic                  ready_in,
    input  logic                  clr_err_in,
    output logic [DIM-1:0][31:0]  query_out,
    output logic [K_W-1:0]        k_out,
    output logic                  valid_out,
    output logic                  busy_out,
    output logic [4:0]            idx_out,
    output logic [4:0]            err_out
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [4:0] IDX_K = 5'(DIM);
`ifdef QUERY_CHECKSUM_EN
    localparam logic [4:0] IDX_HOLD = 5'(DIM + 2);
`else
    localparam logic [4:0] IDX_HOLD = 5'(DIM + 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t               state, next_state;
    logic                 strobe_q;
    logic                 tog;
    logic [4:0]           idx, next_idx;
    logic [TO_W-1:0]      to_cnt, next_to_cnt;
    logic [DIM-1:0][31:0] shadow;
    logic                 shadow_we;
    logic                 load_out;
    logic [4:0]           err_set;
    logic                 k_bad;
    logic [K_W-1:0]       k_load;

`ifdef QUERY_CHECKSUM_EN
    logic [31:0]          sum;
    logic [K_W-1:0]       k_pend;
    logic                 sum_clr;
    logic                 sum_add;
    logic                 k_we;
`endif

    assign tog   = strobe_in ^ strobe_q;
    assign k_bad = ((word_in >> K_W) != 32'd0) || (word_in == 32'd0);

`ifdef QUERY_CHECKSUM_EN
    assign k_load = k_pend;
`else
    assign k_load = word_in[K_W-1:0];
`endif

    // Next-state and control decode
    always_comb begin
        next_state  = state;
        next_idx    = idx;
        next_to_cnt = to_cnt;
        shadow_we   = 1'b0;
        load_out    = 1'b0;
        err_set     = 5'd0;
`ifdef QUERY_CHECKSUM_EN
        sum_clr     = 1'b0;
        sum_add     = 1'b0;
        k_we        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (tog) begin
                    if (word_in == SYNC_WORD) begin
                        next_state  = COLLECT;
                        next_idx    = 5'd0;
                        next_to_cnt = '0;
`ifdef QUERY_CHECKSUM_EN
                        sum_clr     = 1'b1;
`endif
                    end else begin
                        err_set[0] = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (tog) begin
                    next_to_cnt = '0;
                    if (word_in == SYNC_WORD) begin
                        next_idx = 5'd0;
`ifdef QUERY_CHECKSUM_EN
                        sum_clr  = 1'b1;
`endif
                    end else if (idx < IDX_K) begin
                        shadow_we = 1'b1;
                        next_idx  = idx + 5'd1;
`ifdef QUERY_CHECKSUM_EN
                        sum_add   = 1'b1;
`endif
                    end else if (idx == IDX_K) begin
                        if (k_bad) begin
                            err_set[2] = 1'b1;
                            next_state = IDLE;
                        end else begin
`ifdef QUERY_CHECKSUM_EN
                            k_we     = 1'b1;
                            sum_add  = 1'b1;
                            next_idx = idx + 5'd1;
`else
                            load_out   = 1'b1;
                            next_state = HOLD;
`endif
                        end
                    end
`ifdef QUERY_CHECKSUM_EN
                    else begin
                        if (word_in == sum) begin
                            load_out   = 1'b1;
                            next_state = HOLD;
                        end else begin
                            err_set[4] = 1'b1;
                            next_state = IDLE;
                        end
                    end
`endif
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (to_cnt == TO_LAST) begin
                        err_set[1] = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_to_cnt = to_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ready_in) begin
                    next_state = IDLE;
                end
                // Words arriving while a frame is held are discarded, SYNC included
                if (tog) begin
                    err_set[3] = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            strobe_q <= 1'b0;
            idx      <= 5'd0;
            to_cnt   <= '0;
        end else begin
            state    <= next_state;
            strobe_q <= strobe_in;
            idx      <= next_idx;
            to_cnt   <= next_to_cnt;
        end
    end

    // Shadow buffer and the presented frame
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shadow    <= '0;
            query_out <= '0;
            k_out     <= '0;
        end else begin
            for (int i = 0; i < DIM; i++) begin
                if (shadow_we && (idx == 5'(i))) begin
                    shadow[i] <= word_in;
                end
            end
            if (load_out) begin
                query_out <= shadow;
                k_out     <= k_load;
            end
        end
    end

`ifdef QUERY_CHECKSUM_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sum    <= 32'd0;
            k_pend <= '0;
        end else begin
            if (sum_clr) begin
                sum <= 32'd0;
            end else if (sum_add) begin
                sum <= sum + word_in;
            end
            if (k_we) begin
                k_pend <= word_in[K_W-1:0];
            end
        end
    end
`endif

    // A new error in the clearing cycle survives the clear
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_out <= 5'd0;
        end else begin
            err_out <= (clr_err_in ? 5'd0 : err_out) | err_set;
        end
    end

    assign valid_out = (state == HOLD);
    assign busy_out  = (state == COLLECT);

    always_comb begin
        idx_out = 5'd0;
        case (state)
            COLLECT: idx_out = idx;
            HOLD:    idx_out = IDX_HOLD;
            default: idx_out = 5'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_query_frame_loader.sv
// ============================================================================
// Module   : tb_query_frame_loader
// Brief    : Scoreboard bench for query_frame_loader (honours QUERY_CHECKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_query_frame_loader;

    localparam int          DIM     = 8;
    localparam int          K_W     = 16;
    localparam int          TIMEOUT = 20;
    localparam logic [31:0] SYNC    = 32'hFFFF_FFFF;
`ifdef QUERY_CHECKSUM_EN
    localparam int          HOLD_IDX = DIM + 2;
`else
    localparam int          HOLD_IDX = DIM + 1;
`endif

    typedef struct packed {
        logic [DIM-1:0][31:0] q;
        logic [K_W-1:0]       k;
    } frame_t;

    frame_t sb[$];
    frame_t mon_exp;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     valid_cycles = 0;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [31:0]          word = 32'd0;
    logic                 strobe = 1'b0;
    logic                 ready = 1'b0;
    logic                 clr = 1'b0;
    logic [DIM-1:0][31:0] query;
    logic [K_W-1:0]       k;
    logic                 valid;
    logic                 busy;
    logic [4:0]           idx;
    logic [4:0]           err;

    query_frame_loader #(
        .DIM            (DIM),
        .K_W            (K_W),
        .SYNC_WORD      (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst_n),
        .word_in    (word),
        .strobe_in  (strobe),
        .ready_in   (ready),
        .clr_err_in (clr),
        .query_out  (query),
        .k_out      (k),
        .valid_out  (valid),
        .busy_out   (busy),
        .idx_out    (idx),
        .err_out    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frames leave the scoreboard on each valid/ready handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) valid_cycles++;
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    for (int i = 0; i < DIM; i++)
                        check($sformatf("query[%0d]", i), query[i], mon_exp.q[i]);
                    check("k_out", 32'(k), 32'(mon_exp.k));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        word   = w;
        strobe = ~strobe;
        step(1 + gap);
    endtask

    // Sends a whole frame; the final word returns right after its consuming edge
    task automatic send_frame(input frame_t f, input int gap);
        logic [31:0] s;
        s = 32'd0;
        send(SYNC, gap);
        for (int i = 0; i < DIM; i++) begin
            send(f.q[i], gap);
            s = s + f.q[i];
        end
        s = s + 32'(f.k);
`ifdef QUERY_CHECKSUM_EN
        send(32'(f.k), gap);
        send(s, 0);
`else
        send(32'(f.k), 0);
`endif
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        int     vc;

        // Reset values
        rst_n = 1'b0;
        step(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_k", 32'(k), 32'd0);
        check("rst_query_zero", 32'(query == '0), 32'd1);
        rst_n = 1'b1;
        step(100);
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic frame with ready high
        ready = 1'b1;
        f.q[0] = 5; f.q[1] = 7; f.q[2] = 1; f.q[3] = 1;
        f.q[4] = 5; f.q[5] = 7; f.q[6] = 1; f.q[7] = 1;
        f.k = 16'd4;
        sb.push_back(f);
        vc = valid_cycles;
        send_frame(f, 3);
        check("latency_valid", 32'(valid), 32'd1);
        check("hold_idx", 32'(idx), 32'(HOLD_IDX));
        step(1);
        check("valid_dropped", 32'(valid), 32'd0);
        check("valid_one_cycle", 32'(valid_cycles - vc), 32'd1);
        check("query_kept", query[1], 32'd7);
        check("k_kept", 32'(k), 32'd4);

        // Back-pressure, overrun while holding, handshake coinciding with a word
        ready = 1'b0;
        sb.push_back(f);
        send_frame(f, 3);
        step(50);
        check("held_valid", 32'(valid), 32'd1);
        check("held_query", query[0], 32'd5);
        check("held_k", 32'(k), 32'd4);
        send(32'h0000_1234, 0);
        check("overrun_err", 32'(err), 32'd8);
        check("overrun_valid", 32'(valid), 32'd1);
        send(SYNC, 0);
        check("sync_in_hold_idx", 32'(idx), 32'(HOLD_IDX));
        pulse_clr();
        check("clr_err", 32'(err), 32'd0);
        ready = 1'b1;
        send(32'h0000_0055, 0);
        check("ready_tog_valid", 32'(valid), 32'd0);
        check("ready_tog_err", 32'(err), 32'd8);
        check("ready_tog_busy", 32'(busy), 32'd0);
        pulse_clr();

        // Resync mid-frame
        send(SYNC, 3);
        send(32'd11, 3);
        send(32'd12, 3);
        send(32'd13, 3);
        check("partial_idx", 32'(idx), 32'd3);
        check("partial_busy", 32'(busy), 32'd1);
        for (int i = 0; i < DIM; i++) f.q[i] = 32'(100 + i);
        f.k = 16'd2;
        sb.push_back(f);
        send_frame(f, 3);
        check("resync_valid", 32'(valid), 32'd1);
        step(1);
        check("resync_err", 32'(err), 32'd0);

        // Bad k words, stray word, clear priority
        vc = valid_cycles;
        send(SYNC, 1);
        for (int i = 0; i < DIM; i++) send(32'(i + 1), 1);
        send(32'h0001_0000, 0);
        check("kwide_err", 32'(err), 32'd4);
        check("kwide_busy", 32'(busy), 32'd0);
        send(32'd9, 0);
        check("stray_err", 32'(err), 32'd5);
        clr = 1'b1;
        send(32'd9, 0);
        clr = 1'b0;
        check("clr_vs_set", 32'(err), 32'd1);
        pulse_clr();
        check("clr_all", 32'(err), 32'd0);
        send(SYNC, 1);
        for (int i = 0; i < DIM; i++) send(32'(i + 1), 1);
        send(32'd0, 0);
        check("kzero_err", 32'(err), 32'd4);
        step(2);
        check("kbad_no_valid", 32'(valid_cycles - vc), 32'd0);
        pulse_clr();

        // Largest legal k and a random frame
        for (int i = 0; i < DIM; i++) f.q[i] = $urandom & 32'h7FFF_FFFF;
        f.k = 16'hFFFF;
        sb.push_back(f);
        send_frame(f, 2);
        step(1);
        for (int i = 0; i < DIM; i++) f.q[i] = $urandom & 32'h7FFF_FFFF;
        f.k = 16'($urandom_range(1, 65535));
        sb.push_back(f);
        send_frame(f, 1);
        step(1);
        check("good_frames_err", 32'(err), 32'd0);

        // Timeout boundary
        send(SYNC, 0);
        send(32'd1, 0);
        send(32'd2, 0);
        check("to_idx", 32'(idx), 32'd2);
        step(TIMEOUT - 1);
        check("to_not_yet_err", 32'(err), 32'd0);
        check("to_not_yet_busy", 32'(busy), 32'd1);
        step(1);
        check("to_err", 32'(err), 32'd2);
        check("to_busy", 32'(busy), 32'd0);
        check("to_idx_idle", 32'(idx), 32'd0);
        pulse_clr();

`ifdef QUERY_CHECKSUM_EN
        vc = valid_cycles;
        send(SYNC, 1);
        for (int i = 0; i < DIM; i++) send(32'(i + 1), 1);
        send(32'd3, 1);
        check("sum_wait_idx", 32'(idx), 32'(DIM + 1));
        send(32'd1234, 0);
        check("sum_err", 32'(err), 32'd16);
        step(2);
        check("sum_no_valid", 32'(valid_cycles - vc), 32'd0);
        pulse_clr();
`endif

        // Asynchronous reset mid-frame
        send(SYNC, 1);
        send(32'd77, 1);
        #2;
        rst_n  = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_idx", 32'(idx), 32'd0);
        strobe = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("post_rst_err", 32'(err), 32'd0);

        step(5);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
